// File: rtl/vip_uart_receiver.sv
// ---------------------------------------------------------------------------
// vip_uart_receiver
//
// Oversampling 8N1 UART receiver. The serial line is synchronized into the
// i_clk domain, a start bit is detected on a high-to-low transition, its
// middle is re-checked to reject glitches, then eight data bits (LSB first)
// and the stop bit are sampled once per bit period. Good frames are
// delivered on o_data/o_rdy; bad stop bits raise o_err_frame.
//
// Parameters
//   scaler      i_clk cycles per UART bit (even, >= 4)
//
// Ports
//   i_nrst      asynchronous active-low reset
//   i_clk       receiver clock, rising edge
//   i_rx        serial input, idle high
//   i_rdy_clr   consumer acknowledge, clears o_rdy/o_err_frame/o_overflow
//   o_rdy       sticky: a received byte is waiting on o_data
//   o_data      last correctly framed byte
//   o_err_frame sticky: a stop bit was sampled low
//   o_overflow  sticky: a byte arrived while o_rdy was still set
// ---------------------------------------------------------------------------
module vip_uart_receiver #(
  parameter int scaler = 8
) (
  input  logic       i_nrst,
  input  logic       i_clk,
  input  logic       i_rx,
  input  logic       i_rdy_clr,
  output logic       o_rdy,
  output logic [7:0] o_data,
  output logic       o_err_frame,
  output logic       o_overflow
);

  localparam logic [31:0] half_bit_last = 32'(scaler / 2 - 1);
  localparam logic [31:0] full_bit_last = 32'(scaler - 1);

  typedef enum logic [1:0] {
    s_idle,
    s_startbit,
    s_data,
    s_stopbit
  } state_t;

  state_t      state;
  logic [31:0] sample;
  logic [3:0]  bitpos;
  logic [7:0]  shiftreg;

  logic rx_meta;
  logic rx_s;
  logic rx_prev;
  logic [2:0] warm;

  // Two-flop synchronizer plus one history flop for falling-edge detection.
  // The flops reset to the idle level, so right after reset the history
  // does not reflect the real line yet. 'warm' fills with ones over the
  // first three edges; only when warm[2] is set do rx_s and rx_prev both
  // hold real samples, which keeps a line that is already low at reset
  // release from looking like a start edge.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
      warm    <= 3'b000;
    end else begin
      rx_meta <= i_rx;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
      warm    <= {warm[1:0], 1'b1};
    end
  end

  // Receive state machine with registered outputs. The acknowledge clears
  // the sticky flags first; a stop-bit decision in the same cycle then
  // overrides whichever flags it owns, so a delivery wins over the clear
  // (and cannot count as an overflow), while a framing error still lets
  // the clear drop o_rdy and o_overflow.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state       <= s_idle;
      sample      <= 32'd0;
      bitpos      <= 4'd0;
      shiftreg    <= 8'd0;
      o_rdy       <= 1'b0;
      o_data      <= 8'd0;
      o_err_frame <= 1'b0;
      o_overflow  <= 1'b0;
    end else begin
      if (i_rdy_clr) begin
        o_rdy       <= 1'b0;
        o_err_frame <= 1'b0;
        o_overflow  <= 1'b0;
      end

      case (state)
        s_idle: begin
          sample <= 32'd0;
          if (warm[2] && rx_prev && !rx_s) begin
            state <= s_startbit;
          end
        end

        // Re-check the line half a bit in; a high level means the edge
        // was a glitch. Leaving here at mid-bit puts every later sample
        // point at the middle of its bit.
        s_startbit: begin
          if (sample == half_bit_last) begin
            sample <= 32'd0;
            if (!rx_s) begin
              state  <= s_data;
              bitpos <= 4'd0;
            end else begin
              state <= s_idle;
            end
          end else begin
            sample <= sample + 32'd1;
          end
        end

        s_data: begin
          if (sample == full_bit_last) begin
            shiftreg <= {rx_s, shiftreg[7:1]};
            sample   <= 32'd0;
            bitpos   <= bitpos + 4'd1;
            if (bitpos == 4'd7) begin
              state <= s_stopbit;
            end
          end else begin
            sample <= sample + 32'd1;
          end
        end

        s_stopbit: begin
          if (sample == full_bit_last) begin
            sample <= 32'd0;
            state  <= s_idle;
            if (rx_s) begin
              o_data <= shiftreg;
              o_rdy  <= 1'b1;
              if (o_rdy && !i_rdy_clr) begin
                o_overflow <= 1'b1;
              end
            end else begin
              o_err_frame <= 1'b1;
            end
          end else begin
            sample <= sample + 32'd1;
          end
        end

        default: begin
          state  <= s_idle;
          sample <= 32'd0;
        end
      endcase
    end
  end

endmodule

// File: doc/vip_uart_receiver.md
VIP_UART_RECEIVER -- requirements
Module: vip_uart_receiver

Interface
REQ-001 SHALL have parameter scaler, default 8: i_clk cycles per UART bit; legal values are even and >= 4.
REQ-002 SHALL have port i_nrst  input  1  asynchronous active-low reset.
REQ-003 SHALL have port i_clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port i_rx  input  1  serial line; idle high; 8N1 frames, LSB first.
REQ-005 SHALL have port i_rdy_clr  input  1  consumer acknowledge; clears o_rdy, o_err_frame and o_overflow.
REQ-006 SHALL have port o_rdy  output  1  received byte valid; sticky until i_rdy_clr.
REQ-007 SHALL have port o_data  output  8  last good received byte.
REQ-008 SHALL have port o_err_frame  output  1  sticky: stop bit sampled low.
REQ-009 SHALL have port o_overflow  output  1  sticky: new byte delivered while o_rdy=1.

Function
REQ-010 SHALL pass i_rx through a 2-flop synchronizer (reset value 1) plus a third flop for edge detect; all decisions use the synchronized value rx_s.
REQ-011 SHALL implement states idle, startbit, data, stopbit, with a sample counter (32 bit), bitpos (4 bit) and an 8-bit shiftreg.
REQ-012 In idle, SHALL leave idle only on a falling edge of rx_s (previous 1, current 0): go to startbit with sample=0; a line held low never starts a frame.
REQ-013 In startbit, SHALL increment sample each cycle.
REQ-014 In startbit at sample==scaler/2-1: if rx_s=0, go to data with sample=0 and bitpos=0; if rx_s=1, treat as a glitch and return to idle with no flags set.
REQ-015 In data, SHALL sample rx_s at sample==scaler-1.
REQ-016 On each data sample: shiftreg={rx_s,shiftreg[7:1]}, sample=0, bitpos+1; after the 8th bit (bitpos==7), go to stopbit.
REQ-017 In stopbit at sample==scaler-1 with rx_s=1: o_data=shiftreg and o_rdy=1; if o_rdy was already 1, also set o_overflow=1, with o_data overwritten by the new byte.
REQ-018 In stopbit at sample==scaler-1 with rx_s=0: set o_err_frame=1, leave o_data and o_rdy unchanged, discard shiftreg.
REQ-019 After the stopbit sample, SHALL return to idle in both cases.
REQ-020 i_rdy_clr=1 SHALL clear o_rdy, o_err_frame and o_overflow on the next edge.
REQ-021 When i_rdy_clr coincides with a byte delivery: delivery wins (o_rdy=1, o_data updated), o_overflow is not set, and o_err_frame is cleared.
REQ-022 When i_rdy_clr coincides with a frame error: o_err_frame=1, and o_rdy and o_overflow are cleared.
REQ-023 Latency: o_rdy SHALL rise exactly 3 + (scaler/2) + 9*scaler cycles (+/-1) after the falling i_rx edge of the start bit.
REQ-024 Back-to-back frames (stop bit followed immediately by a start bit) SHALL be received without loss.
REQ-025 The sample counter SHALL never exceed scaler-1; there is no wrap-around beyond the 8 data bits.
REQ-026 Outputs SHALL be driven directly from registers, with no combinational path from i_rx.

Reset
REQ-027 While i_nrst=0, SHALL asynchronously force: state=idle, sample=0, bitpos=0, shiftreg=0, synchronizer flops=1, o_rdy=0, o_data=0, o_err_frame=0, o_overflow=0.
REQ-028 Reset asserted mid-frame SHALL abort the frame with no delivery.
REQ-029 After reset release, a line already low SHALL NOT start a frame until a high-to-low transition occurs.

Verification (scaler=8)
REQ-030 Send frame 0xA5 with correct stop bit -> o_rdy=1 at 79 +/- 1 cycles after the start edge, o_data=0xA5, o_err_frame=0, o_overflow=0.
REQ-031 Send 0x3C, then 0xC3 back-to-back with no i_rdy_clr -> o_data=0xC3, o_rdy=1, o_overflow=1; then pulse i_rdy_clr -> all three flags=0.
REQ-032 Send 0x55 with stop bit low, then hold i_rx low for 40 cycles -> o_err_frame=1, o_rdy=0, o_data unchanged, and no new frame starts; a subsequent valid 0x01 frame is received correctly.
REQ-033 Drive i_rx low for 3 cycles only (glitch) -> no o_rdy, no error flag, state back to idle; the following frame 0xFF is received correctly.
REQ-034 Assert i_nrst during data bit 4 of a frame, release it, then send 0x81 -> the aborted frame produces no o_rdy; o_data=0x81 afterwards.
REQ-035 Pulse i_rdy_clr on the exact cycle of a 0x7E delivery while o_rdy=1 -> o_rdy=1, o_data=0x7E, o_overflow=0.
